// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if
//   Beat stream carrying the register file dump from regfile_dump_reader to its
//   consumer (DiffTest / ebreak reporting).
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  sink accepts beat
//   out_idx    master->slave  beat index (0..NUM_REGS-1 registers, NUM_REGS = PC)
//   out_data   master->slave  beat payload
//   out_last   master->slave  final beat of the dump
interface regfile_dump_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   out_idx;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Freezes the core, reads every architectural register through a spare read
//   port and streams them as indexed beats, optionally followed by the PC.
//   clk, rst           clock, asynchronous active-high reset
//   start, abort       begin a dump (IDLE only) / cancel an in-progress dump
//   busy               high whenever not IDLE
//   freeze_req/ack     stall handshake with the core writeback
//   rf_raddr/rf_rdata  spare register file read port (combinational read)
//   pc_in              PC value, sampled on the PC beat
//   done               one-cycle pulse after the final beat is accepted
//   dump               beat stream (master side)
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int INCLUDE_PC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  freeze_req,
    input  logic                  freeze_ack,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  done,
    regfile_dump_reader_if.master dump
);
    localparam int unsigned NUM_REGS = 32'd1 << ADDR_WIDTH;
    localparam int unsigned LAST_INT = (INCLUDE_PC != 0) ? NUM_REGS : NUM_REGS - 1;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = LAST_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PC_IDX   = NUM_REGS[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t state, state_d;

    // idx carries one extra bit so the PC beat index NUM_REGS is representable
    logic [ADDR_WIDTH:0]   idx, idx_d;
    logic                  freeze_req_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH:0]   oidx_q, oidx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  done_d;

    logic handshake;
    assign handshake = valid_q && dump.out_ready;

    assign busy           = (state != S_IDLE);
    assign rf_raddr       = idx[ADDR_WIDTH-1:0];
    assign dump.out_valid = valid_q;
    assign dump.out_idx   = oidx_q;
    assign dump.out_data  = data_q;
    assign dump.out_last  = last_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            freeze_req <= 1'b0;
            valid_q    <= 1'b0;
            oidx_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            freeze_req <= freeze_req_d;
            valid_q    <= valid_d;
            oidx_q     <= oidx_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done       <= done_d;
        end
    end

    // Next state; abort wins over every other transition while dumping
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (start && !abort) state_d = S_FREEZE;
            S_FREEZE: if (abort) state_d = S_IDLE;
                      else if (freeze_ack) state_d = S_FETCH;
            S_FETCH:  state_d = abort ? S_IDLE : S_SEND;
            S_SEND:   if (abort) state_d = S_IDLE;
                      else if (handshake) state_d = last_q ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the beat index
    always_comb begin
        idx_d        = idx;
        freeze_req_d = freeze_req;
        valid_d      = valid_q;
        oidx_d       = oidx_q;
        data_d       = data_q;
        last_d       = last_q;
        done_d       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    idx_d        = '0;
                    freeze_req_d = 1'b1;
                end
            end
            S_FREEZE, S_FETCH, S_SEND: begin
                if (abort) begin
                    // A handshake coinciding with abort is dropped, not counted
                    idx_d        = '0;
                    freeze_req_d = 1'b0;
                    valid_d      = 1'b0;
                    last_d       = 1'b0;
                end else if (state == S_FETCH) begin
                    data_d  = ((INCLUDE_PC != 0) && (idx == PC_IDX)) ? pc_in : rf_rdata;
                    oidx_d  = idx;
                    valid_d = 1'b1;
                    last_d  = (idx == LAST_IDX);
                end else if (state == S_SEND && handshake) begin
                    valid_d = 1'b0;
                    if (last_q) done_d = 1'b1;
                    else        idx_d  = idx + 1'b1;
                end
            end
            S_DONE: begin
                freeze_req_d = 1'b0;
                last_d       = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Drives two instances (with and without the PC beat) from a register file
//   array and checks each dump against a list of expected beats built from the
//   array contents.
module tb_regfile_dump_reader;
    logic        clk;
    logic        rst;
    logic        start, abort, freeze_ack, out_ready, sel;
    logic [31:0] pc_in;
    logic [31:0] rf [32];

    int checks;
    int failures;

    regfile_dump_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_a ();
    regfile_dump_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_b ();

    logic        start_a, start_b;
    logic        busy_a, busy_b, fr_a, fr_b, done_a, done_b;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;

    assign start_a         = start & ~sel;
    assign start_b         = start & sel;
    assign rdata_a         = rf[raddr_a];
    assign rdata_b         = rf[raddr_b];
    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;

    regfile_dump_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .INCLUDE_PC(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .busy(busy_a),
        .freeze_req(fr_a), .freeze_ack(freeze_ack), .rf_raddr(raddr_a),
        .rf_rdata(rdata_a), .pc_in(pc_in), .done(done_a), .dump(bus_a)
    );

    regfile_dump_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .INCLUDE_PC(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .busy(busy_b),
        .freeze_req(fr_b), .freeze_ack(freeze_ack), .rf_raddr(raddr_b),
        .rf_rdata(rdata_b), .pc_in(pc_in), .done(done_b), .dump(bus_b)
    );

    logic        obs_busy, obs_fr, obs_valid, obs_last, obs_done;
    logic [4:0]  obs_raddr;
    logic [5:0]  obs_idx;
    logic [31:0] obs_data;

    assign obs_busy  = sel ? busy_b          : busy_a;
    assign obs_fr    = sel ? fr_b            : fr_a;
    assign obs_done  = sel ? done_b          : done_a;
    assign obs_raddr = sel ? raddr_b         : raddr_a;
    assign obs_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign obs_last  = sel ? bus_b.out_last  : bus_a.out_last;
    assign obs_idx   = sel ? bus_b.out_idx   : bus_a.out_idx;
    assign obs_data  = sel ? bus_b.out_data  : bus_a.out_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
        pc_in = 32'h8000_0010;
    endtask

    // One dump on the selected instance. Optional events: abort at beat
    // abort_at, async reset at beat rst_at, stray start at beat start_at.
    task automatic run_dump(input bit use_b, input int ack_delay, input bit rand_ready,
                            input bit stall7, input int abort_at, input int rst_at,
                            input int start_at);
        logic [31:0] exp_q[$];
        int n_beats, k, since_ack, stall_left, done_cnt;
        bit hs_prev, hs_last_prev, finished, seen_valid, stalled;
        k = 0; since_ack = 0; stall_left = 0; done_cnt = 0;
        hs_prev = 0; hs_last_prev = 0; finished = 0; seen_valid = 0; stalled = 0;
        sel = use_b;
        n_beats = use_b ? 32 : 33;
        for (int i = 0; i < 32; i++) exp_q.push_back(rf[i]);
        if (!use_b) exp_q.push_back(pc_in);
        freeze_ack = 1'b0; out_ready = 1'b1; abort = 1'b0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < ack_delay; c++) begin
            if (c > 0) @(negedge clk);
            chk("freeze_hold", {obs_busy, obs_fr, obs_valid}, 3'b110);
        end
        freeze_ack = 1'b1;

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            since_ack++;
            chk("done_pulse", obs_done, hs_last_prev);
            if (obs_done) done_cnt++;
            if (hs_last_prev) begin
                @(negedge clk);
                chk("post_done", {obs_fr, obs_busy, obs_done, obs_valid}, 4'b0);
                chk("done_count", done_cnt, 1);
                finished = 1;
            end else begin
                if (hs_prev) k++;
                if (obs_valid && !seen_valid) begin
                    seen_valid = 1;
                    chk("ack_to_valid", since_ack, 2);
                end
                if (obs_valid) begin
                    chk("beat_idx", obs_idx, k);
                    chk("beat_data", obs_data, exp_q[k]);
                    chk("beat_last", obs_last, (k == n_beats - 1));
                    chk("rf_raddr", obs_raddr, k[4:0]);
                end else begin
                    chk("busy", obs_busy, 1'b1);
                end

                if (obs_valid && k == abort_at) begin
                    out_ready = 1'b1; abort = 1'b1;
                    @(negedge clk); abort = 1'b0;
                    chk("abort_idle", {obs_busy, obs_valid, obs_fr, obs_done}, 4'b0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_no_done", {obs_done, obs_busy}, 2'b0);
                    end
                    finished = 1;
                end else if (obs_valid && k == rst_at) begin
                    #2 rst = 1'b1;
                    #1 chk("async_rst", {obs_busy, obs_fr, obs_raddr, obs_valid, obs_idx,
                                         obs_data, obs_last, obs_done}, '0);
                    @(negedge clk); rst = 1'b0;
                    chk("rst_quiet", {obs_busy, obs_valid, obs_done}, 3'b0);
                    finished = 1;
                end else begin
                    start = (obs_valid && k == start_at);
                    if (stall7 && obs_valid && k == 7 && !stalled) begin
                        stalled = 1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    hs_prev      = obs_valid && out_ready;
                    hs_last_prev = hs_prev && (k == n_beats - 1);
                end
            end
        end
        chk("completed", finished, 1'b1);
        start = 1'b0; abort = 1'b0; freeze_ack = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        start = 1'b0; abort = 1'b0; freeze_ack = 1'b0; out_ready = 1'b1;
        sel = 1'b0; rst = 1'b0;
        preload();

        #2 rst = 1'b1;
        #1 chk("reset_a", {obs_busy, obs_fr, obs_raddr, obs_valid, obs_idx, obs_data,
                           obs_last, obs_done}, '0);
        chk("reset_b", {busy_b, fr_b, raddr_b, bus_b.out_valid, bus_b.out_idx,
                        bus_b.out_data, bus_b.out_last, done_b}, '0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {obs_busy, obs_fr, obs_valid}, 3'b0);

        // start with abort high stays idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {obs_busy, obs_fr}, 2'b0);

        // full dump with PC, ready tied high, stray start during beat 3
        run_dump(0, 2, 0, 0, -1, -1, 3);
        // random backpressure with a 5-cycle stall on beat 7
        run_dump(0, 2, 1, 1, -1, -1, -1);

        // no-PC instance with random register contents
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        pc_in = $urandom;
        run_dump(1, 3, 1, 0, -1, -1, -1);

        preload();
        // abort at beat 12, then a fresh dump from beat 0
        run_dump(0, 2, 1, 0, 12, -1, -1);
        run_dump(0, 2, 1, 0, -1, -1, -1);
        // long freeze acknowledge delay
        run_dump(0, 20, 0, 0, -1, -1, -1);
        // asynchronous reset at beat 20, then recovery
        run_dump(0, 2, 1, 0, -1, 20, -1);
        run_dump(0, 1, 1, 0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Reads the architectural register file back out through a spare read port and streams it as an indexed valid/ready beat sequence, with the PC optionally appended as a final beat.
- Consumed by the DiffTest / ebreak reporting path; it is the read-side counterpart of the register file write port.
- Freezes the core through a request/acknowledge pair so the dump is a consistent snapshot.

Parameters:
- ADDR_WIDTH, 5, register address width; the block dumps NUM_REGS = 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register and PC data width.
- INCLUDE_PC, 1, when 1 appends pc_in as beat index NUM_REGS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  cancel an in-progress dump
- busy  out  1  high in every state except IDLE
- freeze_req  out  1  asks the core to stall its register writeback
- freeze_ack  in  1  core is stalled; must stay high while freeze_req is high
- rf_raddr  out  ADDR_WIDTH  register file read address
- rf_rdata  in  DATA_WIDTH  register file read data, combinational from rf_raddr
- pc_in  in  DATA_WIDTH  current PC, sampled on the PC beat
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts beat
- out_idx  out  ADDR_WIDTH+1  beat index: 0..NUM_REGS-1 for registers, NUM_REGS for PC
- out_data  out  DATA_WIDTH  beat payload
- out_last  out  1  final beat of the dump
- done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: state=IDLE, idx=0.
  - Outputs 0: busy, freeze_req, rf_raddr, out_valid, out_idx, out_data, out_last, done.
  - Reset is asynchronous and takes effect mid-dump with no done pulse.
- States: IDLE, FREEZE, FETCH, SEND, DONE. All outputs are registered except busy (state != IDLE) and rf_raddr (idx[ADDR_WIDTH-1:0]).
- IDLE:
  - start=1 and abort=0 -> FREEZE next cycle, idx<=0, freeze_req<=1.
  - start while not in IDLE is ignored.
- FREEZE: hold freeze_req; freeze_ack=1 -> FETCH.
- FETCH (one cycle):
  - Data source: rf_raddr=idx; out_data <= (INCLUDE_PC && idx==NUM_REGS) ? pc_in : rf_rdata.
  - Beat fields: out_idx<=idx, out_valid<=1, out_last<=(idx==LAST) with LAST = INCLUDE_PC ? NUM_REGS : NUM_REGS-1.
  - Next state SEND.
  - x0 is not special-cased; its beat carries whatever rf_rdata returns (0).
- SEND:
  - out_valid, out_idx, out_data and out_last stay stable until out_valid&&out_ready.
  - On the handshake, out_valid<=0.
  - If out_last -> DONE; else idx<=idx+1 -> FETCH.
  - Minimum 2 cycles per beat; full dump is at least 2*(LAST+1)+3 cycles including FREEZE and DONE.
- DONE: done=1 for exactly one cycle, freeze_req<=0, out_last<=0 -> IDLE.
- Precedence: abort=1 in FREEZE, FETCH or SEND overrides every other transition in that state.
  - Result: IDLE next cycle; out_valid, out_last and freeze_req cleared; no done; idx<=0.
  - A handshake in the same cycle as abort is discarded.
- abort in IDLE or DONE: no effect; a DONE pulse still completes.
- start and abort both high in IDLE: stay in IDLE.
- freeze_ack is sampled only in FREEZE. Deassertion during FETCH/SEND is a core protocol violation and the block does not check it.
- idx is ADDR_WIDTH+1 bits wide and never wraps: LAST <= NUM_REGS, so idx+1 stays representable.

Test Plan:
- Reg i preloaded with 0x1000+i (x0 reads 0), pc_in=0x80000010, INCLUDE_PC=1, out_ready tied 1, freeze_ack asserted 2 cycles after freeze_req:
  - 33 beats, idx 0..32, data 0, 0x1001..0x101F, then 0x80000010.
  - out_last only on idx 32.
  - done pulses once, one cycle after the idx-32 handshake; freeze_req low the cycle after done.
- Backpressure: out_ready toggles randomly and is held low for 5 cycles on idx 7 -> out_data=0x1007 and out_idx=7 stable throughout; no beat dropped or duplicated.
- INCLUDE_PC=0 -> 32 beats, out_last on idx 31, pc never emitted.
- abort asserted in SEND at idx 12 with out_ready=1 in the same cycle:
  - Next cycle IDLE, out_valid=0, freeze_req=0, no done.
  - A new start restarts at idx 0.
- freeze_ack held low 20 cycles -> block stays in FREEZE with busy=1, out_valid=0, freeze_req=1; proceeds 1 cycle after ack rises.
- rst pulsed asynchronously mid-dump at idx 20 -> all outputs 0 immediately; start while busy (idx 3) ignored, with the sequence continuing unchanged.
